// File: rtl/pll_seq_pkg.sv
// Shared state encoding, width helper and default timing for the PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        LOST      = 3'd5
    } pll_state_e;

    localparam int unsigned DEF_SYNC_STAGES    = 2;
    localparam int unsigned DEF_STABLE_CYCLES  = 1024;
    localparam int unsigned DEF_LOCK_TIMEOUT   = 65536;
    localparam int unsigned DEF_PLL_RST_CYCLES = 16;
    localparam int unsigned DEF_NUM_DOMAINS    = 3;
    localparam int unsigned DEF_STAGE_GAP      = 16;
    localparam int unsigned DEF_CNT_W          = 17;

    // Index width that never collapses to zero bits for a single-entry range.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync.sv
// Level synchronizer for slow asynchronous status inputs; synchronous active-low reset.
module sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb sync_d = {sync_q[STAGES-2:0], d};

    always_ff @(posedge clk) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer with staged domain reset release on the reference clock.
// Optional lock-loss statistics are built when PLL_SEQ_LOCK_STATS_EN is defined.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int unsigned NUM_DOMAINS    = DEF_NUM_DOMAINS,
    parameter int unsigned STAGE_GAP      = DEF_STAGE_GAP,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pll_locked,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst_n,
    output logic                   ready
`ifdef PLL_SEQ_LOCK_STATS_EN
    ,
    output logic [7:0]             relock_count,
    output logic                   lock_lost_sticky,
    input  logic                   clear_stats
`endif
);

    localparam int unsigned STG_W = idx_w(NUM_DOMAINS);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);
    localparam logic [STG_W-1:0] STG_LAST    = STG_W'(NUM_DOMAINS - 1);

    logic lk;

    sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lk)
    );

    pll_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [STG_W-1:0]       stg_q, stg_d;
    logic                   pll_rst_q, pll_rst_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   ready_q, ready_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        stg_d   = stg_q;
        case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            WAIT_LOCK: begin
                if (lk) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                end
            end
            STABLE: begin
                if (!lk) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                    stg_d   = '0;
                end
            end
            RELEASE: begin
                // Last stage is already out, so leave before the gap counter runs again.
                if (!lk) begin
                    state_d = LOST;
                    cnt_d   = '0;
                end else if (stg_q == STG_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    stg_d = stg_q + 1'b1;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!lk) state_d = LOST;
            end
            default: begin
                state_d = PLL_RST;
                cnt_d   = '0;
            end
        endcase

        // Outputs follow the next state so they line up with the state register.
        pll_rst_d = (state_d == PLL_RST);
        ready_d   = (state_d == RUN);
        dom_d     = '0;
        for (int i = 0; i < int'(NUM_DOMAINS); i++) begin
            dom_d[i] = (state_d == RUN) || ((state_d == RELEASE) && (STG_W'(i) <= stg_d));
        end
    end

`ifdef PLL_SEQ_LOCK_STATS_EN
    logic [7:0] rc_q, rc_d, rc_base;
    logic       sticky_q, sticky_d;
    logic       loss_run;

    // A clear in the same cycle as a loss still records that loss.
    always_comb begin
        loss_run = (state_q == RUN) && (state_d == LOST);
        rc_base  = clear_stats ? 8'd0 : rc_q;
        rc_d     = rc_base;
        if (loss_run && (rc_base != 8'hFF)) rc_d = rc_base + 8'd1;
        sticky_d = loss_run | (sticky_q & ~clear_stats);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rc_q     <= '0;
            sticky_q <= 1'b0;
        end else begin
            rc_q     <= rc_d;
            sticky_q <= sticky_d;
        end
    end

    assign relock_count     = rc_q;
    assign lock_lost_sticky = sticky_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= PLL_RST;
            cnt_q     <= '0;
            stg_q     <= '0;
            pll_rst_q <= 1'b1;
            dom_q     <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stg_q     <= stg_d;
            pll_rst_q <= pll_rst_d;
            dom_q     <= dom_d;
            ready_q   <= ready_d;
        end
    end

    assign pll_rst      = pll_rst_q;
    assign domain_rst_n = dom_q;
    assign ready        = ready_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Event-trace scoreboard for pll_lock_sequencer: expected output changes (cycle, value) are queued by stimulus.
module tb_pll_lock_sequencer;

    localparam int P = 16;
    localparam int S = 1024;
    localparam int G = 16;
    localparam int T = 2048;
`ifdef PLL_SEQ_LOCK_STATS_EN
    localparam int OW = 14;
`else
    localparam int OW = 5;
`endif

    typedef struct {
        int            cyc;
        logic [OW-1:0] v;
        string         name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic [2:0] domain_rst_n;
    logic       ready;
`ifdef PLL_SEQ_LOCK_STATS_EN
    logic [7:0] relock_count;
    logic       lock_lost_sticky;
    logic       clear_stats = 1'b0;
    logic [7:0] es_rc = 8'd0;
    logic       es_st = 1'b0;
`endif

    always #5 clk = ~clk;

    pll_lock_sequencer #(.LOCK_TIMEOUT(T)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .pll_rst      (pll_rst),
        .domain_rst_n (domain_rst_n),
        .ready        (ready)
`ifdef PLL_SEQ_LOCK_STATS_EN
        ,
        .relock_count     (relock_count),
        .lock_lost_sticky (lock_lost_sticky),
        .clear_stats      (clear_stats)
`endif
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t expq[$];
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;
    bit   done = 1'b0;
    int   snap_req = 0;

    function automatic logic [OW-1:0] mk(input logic pr, input logic [2:0] d, input logic rd);
`ifdef PLL_SEQ_LOCK_STATS_EN
        return {pr, d, rd, es_rc, es_st};
`else
        return {pr, d, rd};
`endif
    endfunction

    function automatic logic [OW-1:0] outv();
`ifdef PLL_SEQ_LOCK_STATS_EN
        return {pll_rst, domain_rst_n, ready, relock_count, lock_lost_sticky};
`else
        return {pll_rst, domain_rst_n, ready};
`endif
    endfunction

    task automatic stats_exp(input logic [7:0] rc, input logic st);
`ifdef PLL_SEQ_LOCK_STATS_EN
        es_rc = rc;
        es_st = st;
`else
        if (rc == 8'hEE && st) $display("note: stats build disabled");
`endif
    endtask

    task automatic push(input int c, input logic pr, input logic [2:0] d, input logic rd, input string n);
        exp_t e;
        e.cyc  = c;
        e.v    = mk(pr, d, rd);
        e.name = n;
        expq.push_back(e);
    endtask

    // st = edge at which STABLE is entered with lock held from then on.
    task automatic push_release(input int st);
        push(st + S,         1'b0, 3'b001, 1'b0, "dom0_release");
        push(st + S + G,     1'b0, 3'b011, 1'b0, "dom1_release");
        push(st + S + 2 * G, 1'b0, 3'b111, 1'b0, "dom2_release");
        push(st + S + 2 * G + 1, 1'b0, 3'b111, 1'b1, "ready_rise");
    endtask

    task automatic at(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every output change (or a requested snapshot) pops one expected event.
    logic [OW-1:0] prev = '0;
    logic [OW-1:0] cur;
    exp_t          ce;
    int            snap_seen = 0;

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            cur = outv();
            if (cur !== prev || snap_req != snap_seen) begin
                snap_seen = snap_req;
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change: cyc=%0d got=%h", cyc, cur);
                end else begin
                    ce = expq.pop_front();
                    if (ce.cyc != cyc || ce.v !== cur) begin
                        bad++;
                        $display("FAIL %s: got cyc=%0d val=%h, want cyc=%0d val=%h",
                                 ce.name, cyc, cur, ce.cyc, ce.v);
                    end
                end
            end
            prev = cur;
        end
        if (done || cyc > 20000) begin
            if (!done) begin
                total++;
                bad++;
                $display("FAIL watchdog: got cyc=%0d, want done before 20000", cyc);
            end
            while (expq.size() > 0) begin
                ce = expq.pop_front();
                total++;
                bad++;
                $display("FAIL %s: got no change, want cyc=%0d val=%h", ce.name, ce.cyc, ce.v);
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        int r, c0, c2, w2, c3, g, f, h, i;

        // Reset, then locked from the first cycle.
        at(3);
        r          = cyc;
        rst_n      = 1'b1;
        pll_locked = 1'b1;
        mon_en     = 1'b1;
        snap_req   = 1;
        stats_exp(8'd0, 1'b0);
        push(r + 1, 1'b1, 3'b000, 1'b0, "reset_state");
        push(r + P, 1'b0, 3'b000, 1'b0, "pll_rst_fall");
        push_release(r + P + 1);

        // Lock lost in RUN, relock during the PLL reset pulse.
        c0 = r + 1080;
        at(c0);
        pll_locked = 1'b0;
        stats_exp(8'd1, 1'b1);
        push(c0 + 3,  1'b0, 3'b000, 1'b0, "lost_in_run");
        push(c0 + 4,  1'b1, 3'b000, 1'b0, "pll_rst_repulse");
        push(c0 + 20, 1'b0, 3'b000, 1'b0, "pll_rst_fall_relock");
        at(c0 + 5);
        pll_locked = 1'b1;
        push_release(c0 + 21);

`ifdef PLL_SEQ_LOCK_STATS_EN
        at(c0 + 1085);
        clear_stats = 1'b1;
        stats_exp(8'd0, 1'b0);
        push(c0 + 1086, 1'b0, 3'b111, 1'b1, "clear_stats");
        at(c0 + 1086);
        clear_stats = 1'b0;
`endif

        // Lock lost again and held low: PLL re-pulses on timeout, domains stay in reset.
        c2 = c0 + 1090;
        at(c2);
        pll_locked = 1'b0;
        stats_exp(8'd1, 1'b1);
        push(c2 + 3,         1'b0, 3'b000, 1'b0, "lost_again");
        push(c2 + 4,         1'b1, 3'b000, 1'b0, "pll_rst_pulse");
        push(c2 + 20,        1'b0, 3'b000, 1'b0, "wait_lock_entry");
        push(c2 + 20 + T,    1'b1, 3'b000, 1'b0, "timeout_repulse1");
        push(c2 + 36 + T,    1'b0, 3'b000, 1'b0, "timeout_fall1");
        push(c2 + 36 + 2*T,  1'b1, 3'b000, 1'b0, "timeout_repulse2");
        push(c2 + 52 + 2*T,  1'b0, 3'b000, 1'b0, "timeout_fall2");

        // Lock returns; one-cycle glitch near STABLE count 500 restarts the debounce.
        w2 = c2 + 52 + 2 * T;
        c3 = w2 + 10;
        at(c3);
        pll_locked = 1'b1;
        g = c3 + 501;
        at(g);
        pll_locked = 1'b0;
        push(g + 1028, 1'b0, 3'b001, 1'b0, "dom0_after_glitch");
        at(g + 1);
        pll_locked = 1'b1;

        // Loss during RELEASE after bit 0 only; counter must not move.
        f = g + 1033;
        at(f);
        pll_locked = 1'b0;
        push(f + 3,  1'b0, 3'b000, 1'b0, "lost_in_release");
        push(f + 4,  1'b1, 3'b000, 1'b0, "pll_rst_after_release_loss");
        push(f + 20, 1'b0, 3'b000, 1'b0, "wait_lock_after_release_loss");
        at(f + 25);
        pll_locked = 1'b1;
        push_release(f + 28);

        // rst_n in RUN, then the normal sequence from reset.
        h = f + 1090;
        at(h);
        rst_n = 1'b0;
        stats_exp(8'd0, 1'b0);
        push(h + 1, 1'b1, 3'b000, 1'b0, "rst_in_run");
        at(h + 1);
        rst_n = 1'b1;
        push(h + 1 + P, 1'b0, 3'b000, 1'b0, "pll_rst_fall_after_rst");
        push_release(h + 2 + P);

        // Clear coincident with a loss from RUN: the loss is still counted.
        i = h + 1 + 1080;
        at(i);
        pll_locked = 1'b0;
        at(i + 2);
`ifdef PLL_SEQ_LOCK_STATS_EN
        clear_stats = 1'b1;
`endif
        stats_exp(8'd1, 1'b1);
        push(i + 3,  1'b0, 3'b000, 1'b0, "clear_vs_loss");
        push(i + 4,  1'b1, 3'b000, 1'b0, "pll_rst_final");
        push(i + 20, 1'b0, 3'b000, 1'b0, "pll_rst_fall_final");
        at(i + 3);
`ifdef PLL_SEQ_LOCK_STATS_EN
        clear_stats = 1'b0;
`endif
        at(i + 40);
        done = 1'b1;
    end

endmodule
